// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit ALU: owns the register file, launches
// register-to-register ops over valid/ready, and retires results and flags.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs1,
    input  logic [REG_AW-1:0] req_rs2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_o,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [REG_AW-1:0] rd_q;
    logic              accept;
    logic              op_ok;

    assign accept  = req_valid && req_ready;
    assign op_ok   = (req_op == 3'b000) || (req_op == 3'b001);
    assign rd_data = regs[rd_addr];

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first so no path
    // through the case leaves state_nxt unassigned (no inferred latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && op_ok) state_nxt = EXEC;
            EXEC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !reset;
    end

    // NOTE: the register file is cleared on reset because software relies on
    // all registers reading zero afterwards; this rules out a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 3'b000;
            flags      <= 4'b0000;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_q       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (wr_en) regs[wr_addr] <= wr_data;

            if (accept) begin
                rd_q <= req_rd;
                if (op_ok) begin
                    alu_a      <= regs[req_rs1];
                    alu_b      <= regs[req_rs2];
                    alu_opcode <= req_op;
                end else begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end

            // Placed after the preload so the writeback wins an address collision.
            if (state == EXEC) begin
                regs[rd_q] <= alu_out;
                flags      <= {alu_z, alu_n, alu_c, alu_o};
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached
// to the operand/opcode outputs.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [REG_AW-1:0] req_rd, req_rs1, req_rs2;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z, alu_n, alu_c, alu_o;
    logic [3:0]        flags;
    logic              done, err;

    logic              n_inject;
    int                pass_cnt = 0;
    int                total_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o),
        .flags(flags), .done(done), .err(err)
    );

    // ALU stub: Z, C (carry for add, borrow for sub) and O are computed;
    // N is driven from n_inject so its bit position can be checked on its own.
    always_comb begin
        logic [DATA_W:0] wide;
        wide  = '0;
        alu_o = 1'b0;
        if (alu_opcode == 3'b001) begin
            wide  = {1'b0, alu_a} - {1'b0, alu_b};
            alu_o = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (wide[DATA_W-1] != alu_a[DATA_W-1]);
        end else begin
            wide  = {1'b0, alu_a} + {1'b0, alu_b};
            alu_o = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (wide[DATA_W-1] != alu_a[DATA_W-1]);
        end
        alu_out = wide[DATA_W-1:0];
        alu_z   = (wide[DATA_W-1:0] == '0);
        alu_c   = wide[DATA_W];
        alu_n   = n_inject;
    end

    task automatic preload(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic peek(input logic [REG_AW-1:0] a, output logic [DATA_W-1:0] v);
        rd_addr = a;
        #1 v = rd_data;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [REG_AW-1:0] rd,
                             input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    endtask

    task automatic test_reset;
        logic [DATA_W-1:0] v;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL ready_in_reset: got %b expected 0", req_ready);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({done, err, flags} !== 6'b0) $display("FAIL ctrl_after_reset: got %b expected 000000", {done, err, flags});
        else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_opcode} !== '0)
            $display("FAIL alu_after_reset: got a=%h b=%h op=%b expected zeros", alu_a, alu_b, alu_opcode);
        else pass_cnt++;
        for (int i = 0; i < NREGS; i++) begin
            peek(REG_AW'(i), v);
            total_cnt++;
            if (v !== 16'h0000) $display("FAIL reg_after_reset r%0d: got %h expected 0000", i, v);
            else pass_cnt++;
        end
    endtask

    task automatic test_add;
        logic [DATA_W-1:0] v;
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        drive_req(3'b000, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        req_valid = 1'b0;
        total_cnt++;
        if ({alu_a, alu_b, alu_opcode} !== {16'h7FFF, 16'h0001, 3'b000})
            $display("FAIL add_operands: got a=%h b=%h op=%b expected 7fff 0001 000", alu_a, alu_b, alu_opcode);
        else pass_cnt++;
        total_cnt++;
        if ({req_ready, done} !== 2'b00) $display("FAIL add_exec_ctrl: got ready,done=%b expected 00", {req_ready, done});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, err} !== 2'b10) $display("FAIL add_done: got done,err=%b expected 10", {done, err});
        else pass_cnt++;
        total_cnt++;
        if (flags !== 4'b0001) $display("FAIL add_flags: got %b expected 0001", flags);
        else pass_cnt++;
        peek(3'd3, v);
        total_cnt++;
        if (v !== 16'h8000) $display("FAIL add_r3: got %h expected 8000", v);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL add_done_pulse: got %b expected 0", done);
        else pass_cnt++;
    endtask

    task automatic test_sub;
        logic [DATA_W-1:0] v;
        drive_req(3'b001, 3'd4, 3'd1, 3'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        peek(3'd4, v);
        total_cnt++;
        if ({v, flags} !== {16'h0000, 4'b1000}) $display("FAIL sub_zero: got r4=%h flags=%b expected 0000 1000", v, flags);
        else pass_cnt++;
        @(negedge clk);
        drive_req(3'b001, 3'd7, 3'd2, 3'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        peek(3'd7, v);
        total_cnt++;
        if ({v, flags} !== {16'h8002, 4'b0010}) $display("FAIL sub_borrow: got r7=%h flags=%b expected 8002 0010", v, flags);
        else pass_cnt++;
    endtask

    task automatic test_flag_n;
        logic [DATA_W-1:0] v;
        n_inject = 1'b1;
        drive_req(3'b000, 3'd7, 3'd7, 3'd7);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_inject = 1'b0;
        peek(3'd7, v);
        total_cnt++;
        if ({v, flags} !== {16'h0004, 4'b0111}) $display("FAIL flag_n: got r7=%h flags=%b expected 0004 0111", v, flags);
        else pass_cnt++;
    endtask

    task automatic test_unsupported;
        logic [DATA_W-1:0] v;
        @(negedge clk);
        drive_req(3'b011, 3'd3, 3'd2, 3'd2);
        @(negedge clk);
        req_valid = 1'b0;
        total_cnt++;
        if ({done, err, req_ready} !== 3'b111) $display("FAIL unsup_pulse: got done,err,ready=%b expected 111", {done, err, req_ready});
        else pass_cnt++;
        total_cnt++;
        if ({flags, alu_opcode} !== {4'b0111, 3'b000}) $display("FAIL unsup_hold: got flags=%b op=%b expected 0111 000", flags, alu_opcode);
        else pass_cnt++;
        peek(3'd3, v);
        total_cnt++;
        if (v !== 16'h8000) $display("FAIL unsup_r3: got %h expected 8000", v);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, err} !== 2'b00) $display("FAIL unsup_pulse_end: got %b expected 00", {done, err});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] v;
        drive_req(3'b000, 3'd5, 3'd3, 3'd1);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL b2b_exec_ready: got %b expected 0", req_ready);
        else pass_cnt++;
        drive_req(3'b000, 3'd6, 3'd5, 3'd2);
        @(negedge clk);
        total_cnt++;
        if ({done, req_ready} !== 2'b11) $display("FAIL b2b_first_done: got done,ready=%b expected 11", {done, req_ready});
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0;
        total_cnt++;
        if ({alu_a, alu_b, done} !== {16'hFFFF, 16'h0001, 1'b0})
            $display("FAIL b2b_second_operands: got a=%h b=%h done=%b expected ffff 0001 0", alu_a, alu_b, done);
        else pass_cnt++;
        @(negedge clk);
        peek(3'd6, v);
        total_cnt++;
        if ({done, v, flags} !== {1'b1, 16'h0000, 4'b1010})
            $display("FAIL b2b_second_done: got done=%b r6=%h flags=%b expected 1 0000 1010", done, v, flags);
        else pass_cnt++;
    endtask

    task automatic test_collision;
        logic [DATA_W-1:0] v;
        preload(3'd3, 16'h1234);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0005;
        drive_req(3'b000, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        req_valid = 1'b0;
        total_cnt++;
        if (alu_a !== 16'h7FFF) $display("FAIL coll_old_operand: got %h expected 7fff", alu_a);
        else pass_cnt++;
        wr_addr = 3'd3; wr_data = 16'hAAAA;
        @(negedge clk);
        wr_en = 1'b0;
        peek(3'd3, v);
        total_cnt++;
        if (v !== 16'h8000) $display("FAIL coll_writeback_wins: got %h expected 8000", v);
        else pass_cnt++;
        peek(3'd1, v);
        total_cnt++;
        if (v !== 16'h0005) $display("FAIL coll_preload_r1: got %h expected 0005", v);
        else pass_cnt++;
    endtask

    task automatic test_reset_exec;
        logic [DATA_W-1:0] v;
        @(negedge clk);
        drive_req(3'b000, 3'd2, 3'd1, 3'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rst_exec_done: got %b expected 0", done);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({req_ready, flags} !== 5'b10000) $display("FAIL rst_exec_state: got ready,flags=%b expected 10000", {req_ready, flags});
        else pass_cnt++;
        peek(3'd2, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL rst_exec_r2: got %h expected 0000", v);
        else pass_cnt++;
        peek(3'd1, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL rst_exec_r1: got %h expected 0000", v);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rst_exec_no_done: got %b expected 0", done);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; n_inject = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_flag_n();
        test_unsupported();
        test_back_to_back();
        test_collision();
        test_reset_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
